// File: rtl/console_tx_pkg.sv
// Shared types for the memory-mapped console transmitter.
package console_tx_pkg;

  localparam int RAM_ADDR_W = 10;

  typedef logic [RAM_ADDR_W-1:0] RamAddress;
  typedef logic [31:0]           Word;
  typedef logic [7:0]            ConsoleByte;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } ConsoleState;

  localparam RamAddress CONSOLE_ADDR_DEFAULT = RamAddress'('h3FC);

  function automatic logic evenParity(input ConsoleByte b);
    return ^b;
  endfunction

endpackage

// File: rtl/console_tx_if.sv
// Store-side snoop bus between the CPU data port and ram; the console only listens.
interface console_tx_if;
  import console_tx_pkg::*;

  RamAddress ram_address;
  logic      ram_write_enable;
  Word       ram_in;

  modport master (output ram_address, output ram_write_enable, output ram_in);
  modport slave  (input  ram_address, input  ram_write_enable, input  ram_in);

endinterface

// File: rtl/console_tx_fifo.sv
// Synchronous byte FIFO; a push while full is accepted only when a pop frees a slot at the same edge.
module console_fifo
  import console_tx_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  logic       pop,
  input  ConsoleByte din,
  output ConsoleByte dout,
  output logic       empty,
  output logic       full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  ConsoleByte       r_mem [DEPTH];

  logic w_do_push;
  logic w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == (PTR_W+1)'(DEPTH));
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);
  assign dout      = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/console_tx.sv
// Console output snooping CPU stores to CONSOLE_ADDR and serialising them as 8N1 frames.
// Define CONSOLE_PARITY_EN to insert an even-parity bit between the data and stop bits.
module console_tx
  import console_tx_pkg::*;
#(
  parameter RamAddress CONSOLE_ADDR = CONSOLE_ADDR_DEFAULT,
  parameter int        FIFO_DEPTH   = 16,
  parameter int        CLKS_PER_BIT = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  console_tx_if.slave  bus,
  output logic         tx,
  output logic         busy,
  output logic         fifo_full,
  output logic         overflow
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  ConsoleState r_state;
  ConsoleState w_next_state;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [2:0]       r_bit_idx;
  ConsoleByte       r_shift;
  logic             r_parity;
  logic             r_overflow;

  logic       w_push;
  logic       w_pop;
  logic       w_bit_done;
  logic       w_tx;
  logic       w_fifo_empty;
  logic       w_fifo_full;
  ConsoleByte w_fifo_dout;

  assign w_push     = bus.ram_write_enable && (bus.ram_address == CONSOLE_ADDR);
  assign w_bit_done = (r_clk_cnt == CNT_W'(CLKS_PER_BIT - 1));

  console_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (w_push),
    .pop     (w_pop),
    .din     (bus.ram_in[7:0]),
    .dout    (w_fifo_dout),
    .empty   (w_fifo_empty),
    .full    (w_fifo_full)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:  if (!w_fifo_empty) w_next_state = START;
      START: if (w_bit_done) w_next_state = DATA;
      DATA: begin
        if (w_bit_done && r_bit_idx == 3'd7) begin
`ifdef CONSOLE_PARITY_EN
          w_next_state = PARITY;
`else
          w_next_state = STOP;
`endif
        end
      end
`ifdef CONSOLE_PARITY_EN
      PARITY: if (w_bit_done) w_next_state = STOP;
`endif
      STOP:  if (w_bit_done) w_next_state = w_fifo_empty ? IDLE : START;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_pop = ~w_fifo_empty && ((r_state == IDLE) || (r_state == STOP && w_bit_done));
    case (r_state)
      START:   w_tx = 1'b0;
      DATA:    w_tx = r_shift[0];
      PARITY:  w_tx = r_parity;
      default: w_tx = 1'b1;
    endcase
  end

  // A pop always restarts the bit timing, whether from IDLE or straight out of STOP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
    end else if (w_pop) begin
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= w_fifo_dout;
      r_parity  <= evenParity(w_fifo_dout);
    end else if (r_state != IDLE) begin
      if (w_bit_done) begin
        r_clk_cnt <= '0;
        if (r_state == DATA) begin
          r_shift   <= r_shift >> 1;
          r_bit_idx <= r_bit_idx + 3'd1;
        end
      end else begin
        r_clk_cnt <= r_clk_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                              r_overflow <= 1'b0;
    else if (w_push && w_fifo_full && !w_pop)  r_overflow <= 1'b1;
  end

  assign tx        = w_tx;
  assign busy      = (r_state != IDLE) | ~w_fifo_empty;
  assign fifo_full = w_fifo_full;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_console_tx.sv
// Directed self-checking bench for console_tx; follows CONSOLE_PARITY_EN for frame layout.
module tb_console_tx;
  import console_tx_pkg::*;

  localparam int CPB = 4;
`ifdef CONSOLE_PARITY_EN
  localparam int FRAME = 11 * CPB;
`else
  localparam int FRAME = 10 * CPB;
`endif
  localparam RamAddress CADDR = 10'h3FC;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic tx, busy, fifo_full, overflow;

  int checks = 0;
  int errors = 0;

  logic [7:0] stream [18];

  console_tx_if bus();

  console_tx #(
    .CONSOLE_ADDR (CADDR),
    .FIFO_DEPTH   (16),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .tx        (tx),
    .busy      (busy),
    .fifo_full (fifo_full),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Expected line level at cycle pos (1-based) of a frame carrying b.
  function automatic logic expectedTx(input logic [7:0] b, input int pos);
    if (pos <= CPB) return 1'b0;
    if (pos <= 9 * CPB) return b[(pos - CPB - 1) / CPB];
`ifdef CONSOLE_PARITY_EN
    if (pos <= 10 * CPB) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic we, input RamAddress a, input logic [7:0] d);
    bus.ram_write_enable = we;
    bus.ram_address      = a;
    bus.ram_in           = {24'h5A5A5A, d};
  endtask

  task automatic storeByte(input RamAddress a, input logic [7:0] d);
    @(negedge clk);
    applyStimulus(1'b1, a, d);
    @(negedge clk);
    applyStimulus(1'b0, '0, 8'h00);
  endtask

  task automatic checkFrame(input logic [7:0] b, input string tag);
    for (int pos = 1; pos <= FRAME; pos++) begin
      @(negedge clk);
      checkOutput($sformatf("%s_tx%0d", tag, pos), {31'd0, tx}, {31'd0, expectedTx(b, pos)});
    end
  endtask

  initial begin
    applyStimulus(1'b0, '0, 8'h00);
    for (int i = 0; i < 17; i++) stream[i] = 8'(i);
    stream[17] = 8'hAA;

    $display("[TB] reset state");
    repeat (3) @(negedge clk);
    checkOutput("rst_tx",        {31'd0, tx},        32'd1);
    checkOutput("rst_busy",      {31'd0, busy},      32'd0);
    checkOutput("rst_fifo_full", {31'd0, fifo_full}, 32'd0);
    checkOutput("rst_overflow",  {31'd0, overflow},  32'd0);
    reset_n = 1'b1;

    $display("[TB] single byte 0x41");
    storeByte(CADDR, 8'h41);
    checkOutput("t1_pre_tx",   {31'd0, tx},   32'd1);
    checkOutput("t1_pre_busy", {31'd0, busy}, 32'd1);
    checkFrame(8'h41, "t1");
    checkOutput("t1_busy_last", {31'd0, busy}, 32'd1);
    @(negedge clk);
    checkOutput("t1_busy_end", {31'd0, busy}, 32'd0);
    checkOutput("t1_tx_end",   {31'd0, tx},   32'd1);

    $display("[TB] single byte 0x07");
    storeByte(CADDR, 8'h07);
    checkFrame(8'h07, "t6");
    @(negedge clk);
    checkOutput("t6_busy_end", {31'd0, busy}, 32'd0);

    $display("[TB] store to other address");
    storeByte(CADDR - 10'd4, 8'h55);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("t2_tx%0d", i),   {31'd0, tx},   32'd1);
      checkOutput($sformatf("t2_busy%0d", i), {31'd0, busy}, 32'd0);
      @(negedge clk);
    end
    checkOutput("t2_fifo_full", {31'd0, fifo_full}, 32'd0);

    $display("[TB] burst fill, push-on-pop, overflow");
    for (int c = 0; c <= 18 * FRAME + 2; c++) begin
      int k;
      @(negedge clk);
      k = c - 1;
      if (k >= 1 && k <= 18 * FRAME)
        checkOutput($sformatf("t3_tx_e%0d", k), {31'd0, tx},
                    {31'd0, expectedTx(stream[(k - 1) / FRAME], (k - 1) % FRAME + 1)});
      if (k == 15) checkOutput("t3_not_full_e15", {31'd0, fifo_full}, 32'd0);
      if (k == 16) begin
        checkOutput("t3_full_e16",     {31'd0, fifo_full}, 32'd1);
        checkOutput("t3_no_ovf_e16",   {31'd0, overflow},  32'd0);
      end
      if (k == FRAME + 1) begin
        checkOutput("t4_full_after_pushpop", {31'd0, fifo_full}, 32'd1);
        checkOutput("t4_no_ovf_pushpop",     {31'd0, overflow},  32'd0);
      end
      if (k == FRAME + 2) begin
        checkOutput("t3_ovf_set",  {31'd0, overflow},  32'd1);
        checkOutput("t3_full_ovf", {31'd0, fifo_full}, 32'd1);
      end
      if (k == 18 * FRAME + 1) begin
        checkOutput("t3_busy_end", {31'd0, busy}, 32'd0);
        checkOutput("t3_tx_end",   {31'd0, tx},   32'd1);
      end
      if (c <= 16)              applyStimulus(1'b1, CADDR, c[7:0]);
      else if (c == FRAME + 1)  applyStimulus(1'b1, CADDR, 8'hAA);
      else if (c == FRAME + 2)  applyStimulus(1'b1, CADDR, 8'h11);
      else                      applyStimulus(1'b0, '0, 8'h00);
    end

    $display("[TB] async reset mid-frame");
    storeByte(CADDR, 8'hF0);
    repeat (9) @(negedge clk);
    checkOutput("t5_mid_tx",  {31'd0, tx},       32'd0);
    checkOutput("t5_mid_ovf", {31'd0, overflow}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("t5_rst_tx",        {31'd0, tx},        32'd1);
    checkOutput("t5_rst_busy",      {31'd0, busy},      32'd0);
    checkOutput("t5_rst_overflow",  {31'd0, overflow},  32'd0);
    checkOutput("t5_rst_fifo_full", {31'd0, fifo_full}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checkOutput($sformatf("t5_idle_tx%0d", i),   {31'd0, tx},   32'd1);
      checkOutput($sformatf("t5_idle_busy%0d", i), {31'd0, busy}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
